mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Load/store sequencer directly upstream of the 8-bit data memory. Accepts one
//  byte or halfword (2*W) load/store request from the core. Drives the memory's
//  single address/write port one byte per cycle, little-endian.
//  Returns load data, or a store completion, through a valid/ready response handshake.
//  Memory reads are combinational; memory writes commit on the posedge of Clk.
// PARAMETERS
//  W  8  memory data width (bits); halfword = 2*W
//  A  8  memory address width; memory depth 2**A
// PORTS
//  Clk          in   1    single clock, all state on posedge
//  Reset        in   1    synchronous, active-low; sampled on posedge Clk
//  ReqValid     in   1    request present
//  ReqReady     out  1    unit can accept; high only in IDLE and Reset high
//  ReqWrite     in   1    1=store, 0=load
//  ReqHalf      in   1    1=halfword (2 bytes), 0=byte
//  ReqSigned    in   1    byte load: 1=sign-extend, 0=zero-extend; ignored otherwise
//  ReqAddr      in   A    byte address of low byte
//  ReqData      in   2*W  store data; byte store uses [W-1:0]
//  RespValid    out  1    response present; held until accepted
//  RespReady    in   1    consumer accepts response
//  RespData     out  2*W  load result; 0 for stores
//  Busy         out  1    state != IDLE
//  MemWrite     out  1    memory write enable
//  DataAddress  out  A    memory address
//  DataIn       out  W    memory write data
//  DataOut      in   W    memory read data (combinational from DataAddress)
// BEHAVIOUR
//  - States: IDLE -> ACC0 -> [ACC1 if half] -> RESP -> IDLE.
//  - IDLE: ReqReady=1. Accept when ReqValid&ReqReady at the edge. Latch
//    write/half/signed/addr/data, then go to ACC0.
//  - ACC0: DataAddress=addr. On store: MemWrite=1, DataIn=data[W-1:0].
//    On load: capture DataOut into lo byte at the edge.
//  - ACC1: DataAddress=(addr+1) mod 2**A, so 2**A-1 wraps to 0.
//    On store: DataIn=data[2W-1:W]. On load: capture hi byte.
//  - RESP: RespValid=1, RespData stable until RespValid&RespReady at an edge,
//    then IDLE. Back-to-back RESP->IDLE->ACC0, so no accept occurs in RESP.
//  - Load result:
//    byte signed -> {{W{lo[W-1]}},lo}; byte unsigned -> {W'0,lo}; half -> {hi,lo}.
//  - Latency (accept edge = edge 0): byte RespValid seen after edge 1;
//    half after edge 2. Minimum request spacing: byte 3 cycles, half 4 cycles.
//  - Outside ACC states: MemWrite=0, DataAddress=0, DataIn=0.
//  - MemWrite is combinational and additionally gated by Reset: 0 whenever
//    Reset is low, so no write is ever issued during a reset cycle.
//  - Reset low at an edge:
//    state=IDLE; RespValid=0; RespData=0; latched request cleared.
//    Aborts mid-operation. A half store aborted after ACC0 leaves the low byte
//    written and the high byte unwritten. No response is issued for the aborted
//    request. ReqReady=0 while Reset is low.
//  - Simultaneous ReqValid and RespReady in IDLE: the request is accepted;
//    RespReady is ignored.
//  - Request inputs are ignored unless accepted. Changes after accept have no
//    effect.
// TESTING
//  1 Byte store 0xA5 @0x10, then unsigned byte load @0x10
//    -> MemWrite high exactly 1 cycle with DataIn=A5; load RespData=0x00A5 after edge 1.
//  2 Half store 0xBEEF @0x20, then half load @0x20
//    -> mem[0x20]=EF, mem[0x21]=BE; RespData=0xBEEF after edge 2.
//  3 Signed byte load of 0x80 -> RespData=0xFF80; unsigned -> 0x0080.
//  4 Half store 0x1234 @0xFF -> mem[0xFF]=34, mem[0x00]=12 (wrap).
//    Half load @0xFF returns 0x1234.
//  5 Hold RespReady=0 for 5 cycles -> RespValid and RespData stable;
//    ReqReady=0 throughout; ReqValid pulses ignored.
//  6 Reset low during ACC1 of half store 0xCAFE @0x40 -> MemWrite=0 that cycle;
//    mem[0x40]=FE, mem[0x41] unchanged; next cycle IDLE; no RespValid.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a byte-wide data memory: splits byte and
// halfword requests into little-endian single-byte accesses behind a valid/ready response.
module mem_access_unit #(
   parameter int W = 8,
   parameter int A = 8
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           ReqValid,
   output logic           ReqReady,
   input  logic           ReqWrite,
   input  logic           ReqHalf,
   input  logic           ReqSigned,
   input  logic [A-1:0]   ReqAddr,
   input  logic [2*W-1:0] ReqData,
   output logic           RespValid,
   input  logic           RespReady,
   output logic [2*W-1:0] RespData,
   output logic           Busy,
   output logic           MemWrite,
   output logic [A-1:0]   DataAddress,
   output logic [W-1:0]   DataIn,
   input  logic [W-1:0]   DataOut
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

   state_t         state_q, state_d;
   logic           write_q, write_d;
   logic           half_q, half_d;
   logic           signed_q, signed_d;
   logic [A-1:0]   addr_q, addr_d;
   logic [2*W-1:0] data_q, data_d;
   logic [W-1:0]   lo_q, lo_d;
   logic [2*W-1:0] resp_q, resp_d;
   logic           req_ready;
   logic           mem_we;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q  <= IDLE;
         write_q  <= 1'b0;
         half_q   <= 1'b0;
         signed_q <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         lo_q     <= '0;
         resp_q   <= '0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         half_q   <= half_d;
         signed_q <= signed_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         lo_q     <= lo_d;
         resp_q   <= resp_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      half_d      = half_q;
      signed_d    = signed_q;
      addr_d      = addr_q;
      data_d      = data_q;
      lo_d        = lo_q;
      resp_d      = resp_q;
      req_ready   = 1'b0;
      RespValid   = 1'b0;
      mem_we      = 1'b0;
      DataAddress = '0;
      DataIn      = '0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (ReqValid) begin
               write_d  = ReqWrite;
               half_d   = ReqHalf;
               signed_d = ReqSigned;
               addr_d   = ReqAddr;
               data_d   = ReqData;
               state_d  = ACC0;
            end
         end
         ACC0: begin
            DataAddress = addr_q;
            if (write_q) begin
               mem_we = 1'b1;
               DataIn = data_q[W-1:0];
            end else begin
               lo_d = DataOut;
            end
            if (half_q) begin
               state_d = ACC1;
            end else begin
               state_d = RESP;
               if (write_q)
                  resp_d = '0;
               else if (signed_q)
                  resp_d = {{W{DataOut[W-1]}}, DataOut};
               else
                  resp_d = {{W{1'b0}}, DataOut};
            end
         end
         ACC1: begin
            // Address arithmetic is A bits wide, so the top byte wraps to 0.
            DataAddress = addr_q + A'(1);
            if (write_q) begin
               mem_we = 1'b1;
               DataIn = data_q[2*W-1:W];
               resp_d = '0;
            end else begin
               resp_d = {DataOut, lo_q};
            end
            state_d = RESP;
         end
         RESP: begin
            RespValid = 1'b1;
            if (RespReady)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset gating keeps a write from landing in the cycle that aborts it.
   assign ReqReady = req_ready & Reset;
   assign MemWrite = mem_we & Reset;
   assign RespData = resp_q;
   assign Busy     = (state_q != IDLE);

endmodule
